// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared scheduler state/owner types and the beat-counter sizing helper.
package mem_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_LDR} owner_e;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mem_lat_pipe.sv
// mem_lat_pipe: LAT-deep shift register carrying read-valid and beat index to the capture point.
module mem_lat_pipe #(
  parameter int LAT = 1,
  parameter int IW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  logic [LAT-1:0]         r_v;
  logic [LAT-1:0][IW-1:0] r_idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_idx <= '0;
    end else begin
      r_v[0]   <= i_valid;
      r_idx[0] <= i_idx;
      for (int k = 1; k < LAT; k++) begin
        r_v[k]   <= r_v[k-1];
        r_idx[k] <= r_idx[k-1];
      end
    end
  end
  assign o_valid = r_v[LAT-1];
  assign o_idx   = r_idx[LAT-1];
endmodule

// File: rtl/mem_sched.sv
// mem_sched: serialises CPU fetch bursts/reads/writes and loader beats onto one synchronous memory port.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic                          cpu_burst,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [BURST_LEN*DATA_W-1:0]   cpu_rdata,
  output logic                          cpu_stall,
  input  logic                          ldr_req,
  input  logic                          ldr_we,
  input  logic [ADDR_W-1:0]             ldr_addr,
  input  logic [DATA_W-1:0]             ldr_wdata,
  output logic                          ldr_gnt,
  output logic                          ldr_done,
  output logic [DATA_W-1:0]             ldr_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);
  localparam int BW = cnt_w(BURST_LEN);
  state_e              r_state, w_next;
  owner_e              r_owner, w_pick;
  logic                r_rr_ldr, r_we, r_burst, w_issue, w_pv, w_start;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BW-1:0]       r_beat, w_last, w_pidx;
  assign w_issue = r_state == ISSUE;
  assign w_last  = r_burst ? BW'(BURST_LEN - 1) : '0;
  // r_rr_ldr set means the loader wins a tie because the CPU was served last
  assign w_pick  = (cpu_req && (!ldr_req || !r_rr_ldr)) ? OWN_CPU : OWN_LDR;
  assign w_start = r_state == IDLE && (cpu_req || ldr_req);
  mem_lat_pipe #(.LAT(RD_LAT), .IW(BW)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_issue && !r_we),
    .i_idx   (r_beat),
    .o_valid (w_pv),
    .o_idx   (w_pidx)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? ISSUE : IDLE;
      ISSUE:   w_next = r_beat != w_last ? ISSUE : r_we ? DONE : WAIT;
      WAIT:    w_next = (w_pv && w_pidx == w_last) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= OWN_CPU;
      r_rr_ldr  <= 1'b0;
      r_we      <= 1'b0;
      r_burst   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_beat    <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_owner <= w_pick;
        r_we    <= w_pick == OWN_CPU ? cpu_we : ldr_we;
        r_burst <= w_pick == OWN_CPU && cpu_burst && !cpu_we;
        r_addr  <= w_pick == OWN_CPU ? cpu_addr : ldr_addr;
        r_wdata <= w_pick == OWN_CPU ? cpu_wdata : ldr_wdata;
        r_beat  <= '0;
      end else if (w_issue && r_beat != w_last) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_pv && r_owner == OWN_CPU) cpu_rdata[w_pidx*DATA_W +: DATA_W] <= mem_rdata;
      if (w_pv && r_owner == OWN_LDR) ldr_rdata <= mem_rdata;
      if (r_state == DONE) r_rr_ldr <= r_owner == OWN_CPU;
    end
  end
  assign mem_en    = w_issue;
  assign mem_we    = w_issue && r_we;
  assign mem_addr  = w_issue ? r_addr + ADDR_W'(r_beat) : '0;
  assign mem_wdata = (w_issue && r_we) ? r_wdata : '0;
  assign ldr_gnt   = w_issue && r_owner == OWN_LDR;
  assign ldr_done  = r_state == DONE && r_owner == OWN_LDR;
  assign cpu_stall = rst_n && cpu_req && !(r_state == DONE && r_owner == OWN_CPU);
endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: randomized self-checking bench for mem_sched against a transaction-level reference model.
module tb_mem_sched;
  localparam int BL = 3;
  localparam int RL = 1;
  logic        clk = 1'b0, rst_n = 1'b0, fill = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, cpu_burst = 0, ldr_req = 0, ldr_we = 0;
  logic [7:0]  cpu_addr = 0, ldr_addr = 0;
  logic [15:0] cpu_wdata = 0, ldr_wdata = 0, mem_rdata;
  logic [47:0] cpu_rdata;
  logic        cpu_stall, ldr_gnt, ldr_done, mem_en, mem_we;
  logic [15:0] ldr_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic        c2_req = 0;
  logic [7:0]  c2_addr = 0;
  logic [47:0] c2_rdata;
  logic        c2_stall, l2_gnt, l2_done, m2_en, m2_we;
  logic [15:0] l2_rdata, m2_wdata, m2_rdata;
  logic [7:0]  m2_addr;
  logic [15:0] init_mem [256];
  logic [15:0] dev_mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_slot [BL];
  logic [15:0] rq1;
  logic [15:0] rq2 [3];
  logic        pref_cpu;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_sched dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_burst(cpu_burst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_sched #(.RD_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .cpu_req(c2_req), .cpu_we(1'b0), .cpu_burst(1'b1),
    .cpu_addr(c2_addr), .cpu_wdata(16'h0), .cpu_rdata(c2_rdata), .cpu_stall(c2_stall),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(8'h0), .ldr_wdata(16'h0),
    .ldr_gnt(l2_gnt), .ldr_done(l2_done), .ldr_rdata(l2_rdata), .mem_en(m2_en),
    .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata)
  );

  // Memory devices: dut gets a writable RAM with 1-cycle read latency, dut2 a ROM with 3 cycles.
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 256; i++) dev_mem[i] <= init_mem[i];
    else if (mem_en && mem_we) dev_mem[mem_addr] <= mem_wdata;
    rq1 <= dev_mem[mem_addr];
    rq2[0] <= init_mem[m2_addr];
    rq2[1] <= rq2[0];
    rq2[2] <= rq2[1];
  end
  assign mem_rdata = rq1;
  assign m2_rdata  = rq2[2];

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pref_cpu = 1'b1;
    for (int k = 0; k < BL; k++) exp_slot[k] = '0;
  endtask

  task automatic run_cpu(input logic we, input logic burst, input logic [7:0] addr, input logic [15:0] wd);
    int nb, exp_lat, got_lat, nseen, first_en;
    logic [7:0] ea;
    nb = (burst && !we) ? BL : 1;
    exp_lat = we ? 2 : (burst ? BL + RL + 1 : RL + 2);
    cpu_we = we; cpu_burst = burst; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    got_lat = -1; nseen = 0; first_en = -1;
    for (int c = 0; c < 30 && got_lat < 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        ea = addr + 8'(nseen);
        if (first_en < 0) first_en = c;
        n_cmp++; if (mem_addr !== ea) begin n_bad++; $display("FAIL cpu_addr beat %0d: got %h want %h", nseen, mem_addr, ea); end
        n_cmp++; if (mem_we !== we) begin n_bad++; $display("FAIL cpu_mem_we: got %b want %b", mem_we, we); end
        if (we) begin n_cmp++; if (mem_wdata !== wd) begin n_bad++; $display("FAIL cpu_wdata: got %h want %h", mem_wdata, wd); end end
        nseen++;
      end
      if (!cpu_stall) got_lat = c;
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
    n_cmp++; if (got_lat != exp_lat) begin n_bad++; $display("FAIL cpu_latency: got %0d want %0d", got_lat, exp_lat); end
    n_cmp++; if (nseen != nb) begin n_bad++; $display("FAIL cpu_beats: got %0d want %0d", nseen, nb); end
    n_cmp++; if (first_en != 1) begin n_bad++; $display("FAIL cpu_first_strobe: got %0d want 1", first_en); end
    if (we) ref_mem[addr] = wd;
    else for (int k = 0; k < nb; k++) exp_slot[k] = ref_mem[8'(addr + 8'(k))];
    for (int k = 0; k < BL; k++) begin
      n_cmp++; if (cpu_rdata[k*16 +: 16] !== exp_slot[k]) begin n_bad++; $display("FAIL cpu_rdata slot %0d: got %h want %h", k, cpu_rdata[k*16 +: 16], exp_slot[k]); end
    end
    pref_cpu = 1'b0;
  endtask

  task automatic run_ldr(input logic we, input logic [7:0] addr, input logic [15:0] wd);
    int exp_lat, got_lat, gnt_c, ngnt;
    exp_lat = we ? 2 : RL + 2;
    ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
    got_lat = -1; gnt_c = -1; ngnt = 0;
    for (int c = 0; c < 30 && got_lat < 0; c++) begin
      @(negedge clk);
      if (ldr_gnt) begin
        ngnt++; gnt_c = c;
        n_cmp++; if (mem_addr !== addr || mem_we !== we) begin n_bad++; $display("FAIL ldr_access: got %h/%b want %h/%b", mem_addr, mem_we, addr, we); end
      end
      if (ldr_done) got_lat = c;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (got_lat != exp_lat) begin n_bad++; $display("FAIL ldr_latency: got %0d want %0d", got_lat, exp_lat); end
    n_cmp++; if (gnt_c != 1 || ngnt != 1) begin n_bad++; $display("FAIL ldr_gnt: got cycle %0d count %0d want cycle 1 count 1", gnt_c, ngnt); end
    if (!we) begin
      n_cmp++; if (ldr_rdata !== ref_mem[addr]) begin n_bad++; $display("FAIL ldr_rdata: got %h want %h", ldr_rdata, ref_mem[addr]); end
    end else ref_mem[addr] = wd;
    ldr_req = 1'b0;
    pref_cpu = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b1; cpu_burst = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin n_bad++; $display("FAIL reset_mem: got %b %b %h %h want 0", mem_en, mem_we, mem_addr, mem_wdata); end
    n_cmp++; if ({ldr_gnt, ldr_done, ldr_rdata, cpu_rdata} !== '0) begin n_bad++; $display("FAIL reset_data: got %b %b %h %h want 0", ldr_gnt, ldr_done, ldr_rdata, cpu_rdata); end
    cpu_req = 1'b0;
    fill = 1'b0;
    do_reset();
  endtask

  task automatic test_burst();
    run_cpu(1'b0, 1'b1, 8'h10, 16'h0);
    n_cmp++; if (cpu_rdata !== 48'h3333_2222_1111) begin n_bad++; $display("FAIL burst_image: got %h want 333322221111", cpu_rdata); end
  endtask

  task automatic test_write_read();
    run_cpu(1'b1, 1'b0, 8'h20, 16'hBEEF);
    run_cpu(1'b0, 1'b0, 8'h20, 16'h0);
    n_cmp++; if (cpu_rdata[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL write_readback: got %h want beef", cpu_rdata[15:0]); end
  endtask

  task automatic run_pair(input logic [7:0] addr, input logic [15:0] dc, input logic [15:0] dl);
    int cs, lg, ld, e_cs, e_lg, e_ld;
    logic cpu_first;
    cpu_first = pref_cpu;
    e_cs = cpu_first ? 2 : 5;
    e_lg = cpu_first ? 4 : 1;
    e_ld = cpu_first ? 5 : 2;
    cpu_we = 1'b1; cpu_burst = 1'b0; cpu_addr = addr; cpu_wdata = dc;
    ldr_we = 1'b1; ldr_addr = addr; ldr_wdata = dl;
    cpu_req = 1'b1; ldr_req = 1'b1;
    cs = -1; lg = -1; ld = -1;
    for (int c = 0; c < 40 && (cs < 0 || ld < 0); c++) begin
      @(negedge clk);
      if (ldr_gnt && lg < 0) lg = c;
      if (cpu_req && !cpu_stall) cs = c;
      if (ldr_done) ld = c;
      @(posedge clk);
      #1;
      if (cs >= 0) cpu_req = 1'b0;
      if (ld >= 0) ldr_req = 1'b0;
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    n_cmp++; if (cs != e_cs) begin n_bad++; $display("FAIL pair_cpu_done: got %0d want %0d", cs, e_cs); end
    n_cmp++; if (lg != e_lg) begin n_bad++; $display("FAIL pair_ldr_gnt: got %0d want %0d", lg, e_lg); end
    n_cmp++; if (ld != e_ld) begin n_bad++; $display("FAIL pair_ldr_done: got %0d want %0d", ld, e_ld); end
    ref_mem[addr] = cpu_first ? dl : dc;
    pref_cpu = cpu_first;
  endtask

  task automatic test_arbitration();
    do_reset();
    run_pair(8'h50, 16'hC0C0, 16'h1D1D);
    run_cpu(1'b0, 1'b0, 8'h50, 16'h0);
    run_pair(8'h51, 16'hC1C1, 16'h1E1E);
    run_cpu(1'b0, 1'b0, 8'h51, 16'h0);
    run_ldr(1'b0, 8'h50, 16'h0);
  endtask

  task automatic test_wrap();
    run_cpu(1'b0, 1'b1, 8'hFE, 16'h0);
  endtask

  task automatic test_reset_mid_burst();
    cpu_we = 1'b0; cpu_burst = 1'b1; cpu_addr = 8'h30; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (!mem_en || mem_addr !== 8'h31) begin n_bad++; $display("FAIL midburst_beat2: got %b %h want 1 31", mem_en, mem_addr); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_en, mem_addr, cpu_stall} !== '0) begin n_bad++; $display("FAIL async_reset_port: got %b %h %b want 0", mem_en, mem_addr, cpu_stall); end
    n_cmp++; if (cpu_rdata !== '0) begin n_bad++; $display("FAIL async_reset_rdata: got %h want 0", cpu_rdata); end
    cpu_req = 1'b0;
    do_reset();
    run_cpu(1'b0, 1'b1, 8'h40, 16'h0);
  endtask

  task automatic test_rdlat3();
    logic [7:0] base;
    int got_lat;
    for (int t = 0; t < 3; t++) begin
      base = t == 0 ? 8'hFE : 8'($urandom_range(0, 255));
      c2_addr = base; c2_req = 1'b1; got_lat = -1;
      for (int c = 0; c < 30 && got_lat < 0; c++) begin
        @(negedge clk);
        if (!c2_stall) got_lat = c;
        @(posedge clk);
        #1;
      end
      c2_req = 1'b0;
      n_cmp++; if (got_lat != BL + 3 + 1) begin n_bad++; $display("FAIL lat3_latency: got %0d want %0d", got_lat, BL + 4); end
      for (int k = 0; k < BL; k++) begin
        n_cmp++; if (c2_rdata[k*16 +: 16] !== init_mem[8'(base + 8'(k))]) begin n_bad++; $display("FAIL lat3_slot %0d: got %h want %h", k, c2_rdata[k*16 +: 16], init_mem[8'(base + 8'(k))]); end
      end
    end
  endtask

  task automatic test_random();
    int op;
    logic [7:0] a;
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 4);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom_range(0, 255));
      case (op)
        0: run_cpu(1'b1, 1'($urandom_range(0, 1)), a, 16'($urandom));
        1: run_cpu(1'b0, 1'b0, a, 16'h0);
        2: run_cpu(1'b0, 1'b1, a, 16'h0);
        3: run_ldr(1'b1, a, 16'($urandom));
        default: run_ldr(1'b0, a, 16'h0);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) init_mem[i] = 16'($urandom);
    init_mem[8'h10] = 16'h1111; init_mem[8'h11] = 16'h2222; init_mem[8'h12] = 16'h3333;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
    pref_cpu = 1'b1;
    for (int k = 0; k < BL; k++) exp_slot[k] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_burst();
    test_write_read();
    test_arbitration();
    test_wrap();
    test_reset_mid_burst();
    test_rdlat3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
